// File: rtl/bcd_display_formatter.sv
// Multi-channel display data path: selects a signed sample, scales it and converts it
// to a sign + BCD frame with a serial double-dabble engine, or passes the raw hex nibbles.
module bcd_display_formatter #(
  parameter int DATA_W      = 16,
  parameter int NUM_CH      = 4,
  parameter int DIGITS      = 4,
  parameter int SCALE_MUL   = 9,
  parameter int SCALE_SHIFT = 10,
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [CW-1:0]            ch_sel,
  input  logic                     hex_mode,
  input  logic [NUM_CH*DATA_W-1:0] data_in,
  output logic                     busy,
  output logic                     done,
  output logic                     ovf,
  output logic [4*DIGITS-1:0]      digits
);

  localparam int PW    = DATA_W + 8;
  localparam int MW    = 4 * (DIGITS - 1);
  localparam int CNT_W = $clog2(PW + 1);

  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  localparam logic [PW-1:0] LIMIT = PW'(pow10(DIGITS - 1) - 1);

  // Handshake: start is a level sampled on every clock edge while idle; busy is high
  // from the accepting edge until the edge that publishes the frame, where done pulses
  // for exactly one cycle. Requests seen while busy are dropped, not queued.
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SCALE,
    S_CONV,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic [DATA_W-1:0] sample_q;
  logic              hex_q;
  logic              sign_q;
  logic [DATA_W-1:0] mag_q;
  logic [PW-1:0]     bin_q;
  logic [MW-1:0]     bcd_q;
  logic [CNT_W-1:0]  cnt;
  logic              sat_q;

  int                sel_idx;
  logic [DATA_W-1:0] sel_sample;
  logic [PW-1:0]     prod;
  logic [PW-1:0]     scaled;
  logic [MW-1:0]     bcd_adj;
  logic [MW-1:0]     bcd_nx;
  logic [PW-1:0]     bin_nx;
  logic [3:0]        sign_digit;
  logic [4*DIGITS-1:0] dec_frame;
  logic [4*DIGITS-1:0] hex_frame;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (start) state_nx = S_LOAD;
      S_LOAD:  state_nx = hex_q ? S_DONE : S_SCALE;
      S_SCALE: state_nx = S_CONV;
      S_CONV:  if (cnt == CNT_W'(PW - 1)) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

  // Out-of-range channel selects fall back to channel 0.
  always_comb begin
    sel_idx = 0;
    if (int'(ch_sel) < NUM_CH) sel_idx = int'(ch_sel);
    sel_sample = data_in[sel_idx*DATA_W +: DATA_W];
  end

  assign prod   = {8'b0, mag_q} * PW'(SCALE_MUL);
  assign scaled = prod >> SCALE_SHIFT;

  // One double-dabble step: correct every BCD nibble, then shift in the next binary bit.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS - 1; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    {bcd_nx, bin_nx} = {bcd_adj, bin_q} << 1;
  end

  always_comb begin
    sign_digit = 4'hA;
    if (sign_q && (sat_q || (|bcd_q))) sign_digit = 4'hF;
    if (sat_q) dec_frame = {sign_digit, {(DIGITS-1){4'h9}}};
    else       dec_frame = {sign_digit, bcd_q};
    hex_frame = {4'h0, sample_q[DATA_W-1 -: MW]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_q <= '0;
      hex_q    <= 1'b0;
      sign_q   <= 1'b0;
      mag_q    <= '0;
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt      <= '0;
      sat_q    <= 1'b0;
      done     <= 1'b0;
      ovf      <= 1'b0;
      digits   <= {4'hA, {(DIGITS-1){4'h0}}};
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            sample_q <= sel_sample;
            hex_q    <= hex_mode;
          end
        end
        S_LOAD: begin
          // Negation as unsigned: the most-negative sample becomes 2^(DATA_W-1).
          sign_q <= sample_q[DATA_W-1];
          mag_q  <= sample_q[DATA_W-1] ? (~sample_q + DATA_W'(1)) : sample_q;
        end
        S_SCALE: begin
          bin_q <= scaled;
          bcd_q <= '0;
          cnt   <= '0;
          sat_q <= (scaled > LIMIT);
        end
        S_CONV: begin
          bin_q <= bin_nx;
          bcd_q <= bcd_nx;
          cnt   <= cnt + CNT_W'(1);
        end
        S_DONE: begin
          done <= 1'b1;
          if (hex_q) begin
            digits <= hex_frame;
          end else begin
            digits <= dec_frame;
            ovf    <= sat_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
